// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: frame-buffered, time-multiplexed 7-segment digit scanner
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  input  logic                    lz_suppress,
  output logic                    ready,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_L,
  output logic                    frame_tick
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active, shadow, act_n;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    commit, last_cnt, last_idx, blank, hide, z;
  logic [3:0]              nib;
  // cnt/idx describe the slot position presented on the outputs after the next edge;
  // a commit is forwarded so the first slot of the new frame already shows the new value
  always_comb begin
    commit   = frame_tick && !ready;
    act_n    = commit ? shadow : active;
    last_cnt = cnt == CW'(REFRESH_DIV - 1);
    last_idx = idx == IW'(NUM_DIGITS - 1);
    blank    = cnt < CW'(BLANK_CYCLES);
    sup      = '0;
    z        = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      z      = z && (act_n[4*d +: 4] == 4'h0);
      sup[d] = z && (d > 0);
    end
    nib  = act_n[4*idx +: 4];
    hide = lz_suppress && sup[idx];
  end
  // scan sequencing, load/commit handshake and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      ready      <= 1'b1;
      an_L       <= '1;
      bcd_out    <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= last_cnt ? '0 : cnt + 1'b1;
      if (last_cnt) idx <= last_idx ? '0 : idx + 1'b1;
      active     <= act_n;
      if (load && ready) shadow <= value_bcd;
      ready      <= commit || (ready && !load);
      bcd_out    <= hide ? 4'hF : nib;
      an_L       <= (blank || hide) ? '1 : ~(NUM_DIGITS'(1) << idx);
      frame_tick <= last_cnt && last_idx;
    end
  end
endmodule
